// File: rtl/ntt_stage_feeder.sv
// Buffered sequencer around a combinational GS butterfly: loads N coefficients, runs one NTT stage in place, unloads.
// Define NTT_FEEDER_BITREV_EN to unload in bit-reversed index order; natural order otherwise.
module ntt_stage_feeder #(
  parameter int N     = 8,
  parameter int LOG_N = 3,
  parameter int DW    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic               start,
  input  logic [LOG_N-1:0]   span,
  input  logic               unload,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [LOG_N-2:0]   tw_addr,
  input  logic [DW-1:0]      tw_data,
  output logic [DW-1:0]      bf_left,
  output logic [DW-1:0]      bf_right,
  output logic [DW-1:0]      bf_w,
  input  logic [DW-1:0]      bf_even,
  input  logic [DW-1:0]      bf_odd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data
);

  localparam int TW_W = LOG_N - 1;
  localparam logic [LOG_N-1:0] LAST     = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] HALF     = LOG_N'(N / 2);
  localparam logic [LOG_N-1:0] RUN_LAST = LOG_N'(N / 2 + 1);

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_RUN, S_UNLOAD} state_t;
  state_t state_q, state_d;

  logic [DW-1:0]    mem [N];
  logic [LOG_N-1:0] cnt_q;
  logic [LOG_N-1:0] span_q, sh_q, sh_d;
  logic             span_legal;
  logic [LOG_N-1:0] mask, j, li, ri, j_shift, ridx;
  logic             v1_q, v2_q;
  logic [LOG_N-1:0] li1_q, ri1_q, li2_q, ri2_q;
  logic [DW-1:0]    left1_q, right1_q;
  logic             load_fire, out_fire, issue;

  assign span_legal = (span != '0) && ((span & (span - 1'b1)) == '0) && (span <= HALF);
  assign load_fire  = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign issue      = (state_q == S_RUN) && (cnt_q < HALF);

  // Twiddle stride N/(2*span) expressed as a left shift of j.
  always_comb begin
    sh_d = '0;
    for (int unsigned i = 0; i < LOG_N; i++)
      if (span[i]) sh_d = LOG_N'(LOG_N - 1 - i);
  end

  // Span is a power of two, so k/span and k%span reduce to masking.
  assign mask    = span_q - 1'b1;
  assign j       = cnt_q & mask;
  assign li      = ((cnt_q & ~mask) << 1) | j;
  assign ri      = li + span_q;
  assign j_shift = j << sh_q;

`ifdef NTT_FEEDER_BITREV_EN
  always_comb begin
    ridx = '0;
    for (int unsigned i = 0; i < LOG_N; i++) ridx[LOG_N-1-i] = cnt_q[i];
  end
`else
  assign ridx = cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:   if (load_fire && cnt_q == LAST) state_d = S_WAIT;
      S_WAIT: begin
        if (start) begin
          if (span_legal) state_d = S_RUN;
        end else if (unload) begin
          state_d = S_UNLOAD;
        end
      end
      S_RUN:    if (cnt_q == RUN_LAST) state_d = S_WAIT;
      S_UNLOAD: if (out_fire && cnt_q == LAST) state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_LOAD);
    busy      = (state_q == S_RUN);
    out_valid = (state_q == S_UNLOAD);
    out_data  = mem[ridx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      span_q   <= '0;
      sh_q     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      tw_addr  <= '0;
      bf_left  <= '0;
      bf_right <= '0;
      bf_w     <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      li1_q    <= '0;
      ri1_q    <= '0;
      li2_q    <= '0;
      ri2_q    <= '0;
      left1_q  <= '0;
      right1_q <= '0;
    end else begin
      done <= (state_q == S_RUN) && (cnt_q == RUN_LAST);
      err  <= (state_q == S_WAIT) && start && !span_legal;
      unique case (state_q)
        S_LOAD:   if (load_fire) cnt_q <= cnt_q + 1'b1;
        S_WAIT: begin
          cnt_q <= '0;
          if (start && span_legal) begin
            span_q <= span;
            sh_q   <= sh_d;
          end
        end
        S_RUN:    cnt_q <= (cnt_q == RUN_LAST) ? '0 : cnt_q + 1'b1;
        S_UNLOAD: if (out_fire) cnt_q <= cnt_q + 1'b1;
        default:  cnt_q <= '0;
      endcase
      // Stage 1 presents tw_addr; stage 2 aligns L/R with the registered twiddle.
      v1_q <= issue;
      if (issue) begin
        li1_q    <= li;
        ri1_q    <= ri;
        left1_q  <= mem[li];
        right1_q <= mem[ri];
        tw_addr  <= j_shift[TW_W-1:0];
      end
      v2_q <= v1_q;
      if (v1_q) begin
        li2_q    <= li1_q;
        ri2_q    <= ri1_q;
        bf_left  <= left1_q;
        bf_right <= right1_q;
        bf_w     <= tw_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) mem[cnt_q] <= in_data;
    if (v2_q && state_q == S_RUN) begin
      mem[li2_q] <= bf_even;
      mem[ri2_q] <= bf_odd;
    end
  end

endmodule

// File: tb/tb_ntt_stage_feeder.sv
// Directed bench for ntt_stage_feeder with a q=17 butterfly, W[a]=a+1 ROM and a scoreboard of expected words.
module tb_ntt_stage_feeder;
  localparam int N = 8, LOG_N = 3, DW = 32;
  localparam logic [63:0] Q = 64'd17;

  logic clk, rst_n, in_valid, in_ready, start, unload, busy, done, err, out_valid, out_ready;
  logic [DW-1:0] in_data, tw_data, bf_left, bf_right, bf_w, bf_even, bf_odd, out_data;
  logic [LOG_N-1:0] span;
  logic [LOG_N-2:0] tw_addr;

  int n_vec = 0, n_err = 0;
  logic [DW-1:0] model [N];
  logic [DW-1:0] exp_q [$];
  logic [63:0]   tw_q  [$];

  ntt_stage_feeder #(.N(N), .LOG_N(LOG_N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .start(start), .span(span), .unload(unload), .busy(busy), .done(done), .err(err),
    .tw_addr(tw_addr), .tw_data(tw_data), .bf_left(bf_left), .bf_right(bf_right), .bf_w(bf_w),
    .bf_even(bf_even), .bf_odd(bf_odd), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tw_data = DW'(tw_addr) + 1;
  assign bf_even = DW'((64'(bf_left) + 64'(bf_right)) % Q);
  assign bf_odd  = DW'((64'(bf_w) * ((64'(bf_left) + Q - 64'(bf_right)) % Q)) % Q);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int rev_idx(input int i);
    int r;
    r = i;
`ifdef NTT_FEEDER_BITREV_EN
    r = 0;
    for (int b = 0; b < LOG_N; b++)
      if (((i >> b) & 1) != 0) r |= 1 << (LOG_N - 1 - b);
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seq();
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      model[i] = DW'(i);
      chk("in_ready_load", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    chk("in_ready_wait", 64'(in_ready), 64'd0);
  endtask

  task automatic run_stage(input int s, input logic with_unload);
    logic [DW-1:0] nm [N];
    logic [63:0] w, l, r;
    int t;
    for (int i = 0; i < N; i++) nm[i] = model[i];
    for (int i = 0; i < N; i++) begin
      if ((i & s) == 0) begin
        w = 64'((i % s) * (N / (2 * s)));
        tw_q.push_back(w);
        l = 64'(model[i]);
        r = 64'(model[i + s]);
        nm[i]     = DW'((l + r) % Q);
        nm[i + s] = DW'(((w + 1) * ((l + Q - r) % Q)) % Q);
      end
    end
    for (int i = 0; i < N; i++) model[i] = nm[i];
    start = 1'b1; span = LOG_N'(s); unload = with_unload;
    tick();
    start = 1'b0; unload = 1'b0;
    chk("busy_run", 64'(busy), 64'd1);
    t = 0;
    while (t < 20) begin
      tick();
      t++;
      if (t <= N / 2 && tw_q.size() > 0) chk("tw_addr", 64'(tw_addr), tw_q.pop_front());
      if (done === 1'b1) break;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("run_cycles", 64'(t), 64'(N / 2 + 2));
    chk("busy_after", 64'(busy), 64'd0);
    tick();
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  task automatic bad_start(input int s);
    start = 1'b1; span = LOG_N'(s);
    tick();
    start = 1'b0;
    chk("err_pulse", 64'(err), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    tick();
    chk("err_clear", 64'(err), 64'd0);
    chk("err_nodone", 64'(done), 64'd0);
    chk("err_busy2", 64'(busy), 64'd0);
  endtask

  task automatic unload_seq(input logic bp);
    logic rdy, vld;
    int c, xfers;
    for (int i = 0; i < N; i++) exp_q.push_back(model[rev_idx(i)]);
    unload = 1'b1;
    tick();
    unload = 1'b0;
    c = 0; xfers = 0;
    while (c < 200 && exp_q.size() > 0) begin
      vld = out_valid;
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_data", 64'(out_data), 64'(exp_q[0]));
      rdy = bp ? ((c % 3) == 0) : 1'b1;
      out_ready = rdy;
      tick();
      if (rdy && vld === 1'b1) begin
        void'(exp_q.pop_front());
        xfers++;
      end
      c++;
    end
    out_ready = 1'b0;
    chk("xfer_count", 64'(xfers), 64'(N));
    chk("out_valid_end", 64'(out_valid), 64'd0);
    chk("in_ready_end", 64'(in_ready), 64'd1);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; start = 1'b0; span = '0;
    unload = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_tw_addr", 64'(tw_addr), 64'd0);
    chk("rst_bf_left", 64'(bf_left), 64'd0);
    chk("rst_bf_w", 64'(bf_w), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Stage span=4
    load_seq();
    run_stage(4, 1'b0);
    unload_seq(1'b0);

    // Stage span=1, with a simultaneous unload pulse that start must override
    load_seq();
    run_stage(1, 1'b1);
    unload_seq(1'b0);

    // Illegal spans, then a back-pressured unload of the untouched buffer
    load_seq();
    bad_start(3);
    bad_start(0);
    bad_start(6);
    unload_seq(1'b1);

    // Reset while pair 2 is being issued
    load_seq();
    start = 1'b1; span = LOG_N'(4);
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tw_addr", 64'(tw_addr), 64'd0);
    chk("mid_rst_bf_left", 64'(bf_left), 64'd0);
    chk("mid_rst_bf_right", 64'(bf_right), 64'd0);
    chk("mid_rst_bf_w", 64'(bf_w), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    load_seq();
    run_stage(4, 1'b0);
    unload_seq(1'b0);

    // Unload straight after load
    load_seq();
    unload_seq(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
